// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, reset/NOP constants and word typedefs.
package cpu_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] instr_t;
  typedef logic [XLEN-1:0] addr_t;

  localparam instr_t NOP_INSTR_C = 32'h0000_0013;
  localparam addr_t  RESET_PC_C  = 32'h0000_0000;

  // Sequential fetch step; the add wraps naturally modulo 2^XLEN.
  function automatic addr_t pc_inc(input addr_t pc);
    return pc + addr_t'(4);
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register: redirect beats hold, hold beats sequential increment.
module pc_reg
  import cpu_pkg::*;
#(
  parameter addr_t RESET_PC = RESET_PC_C
) (
  input  logic  clk_i,
  input  logic  rst_n_i,
  input  logic  branch_taken,
  input  addr_t branch_target,
  input  logic  stall,
  output addr_t pc
);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pc <= RESET_PC;
    end else if (branch_taken) begin
      pc <= branch_target;
    end else if (!stall) begin
      pc <= pc_inc(pc);
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// Fetch stage plus IF/ID pipeline register. Optional bubble counter is enabled
// by defining IF_ID_BUBBLE_CNT_EN.
module if_id_stage
  import cpu_pkg::*;
#(
  parameter addr_t  RESET_PC  = RESET_PC_C,
  parameter instr_t NOP_INSTR = NOP_INSTR_C
) (
  input  logic   clk_i,
  input  logic   rst_n_i,
  output addr_t  pc_o,
  input  instr_t imem_data_i,
  input  logic   stall_i,
  input  logic   flush_i,
  input  logic   branch_taken_i,
  input  addr_t  branch_target_i,
  output instr_t instr_o,
  output addr_t  pc_id_o,
  output logic   valid_o
`ifdef IF_ID_BUBBLE_CNT_EN
  ,
  output logic [XLEN-1:0] bubble_cnt_o
`endif
);

  addr_t pc;
  logic  load_bubble;

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .branch_taken (branch_taken_i),
    .branch_target(branch_target_i),
    .stall        (stall_i),
    .pc           (pc)
  );

  assign pc_o = pc;

  // A taken branch squashes the wrong-path fetch even when decode is stalling.
  assign load_bubble = flush_i | branch_taken_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      instr_o <= NOP_INSTR;
      pc_id_o <= RESET_PC;
      valid_o <= 1'b0;
    end else if (load_bubble) begin
      instr_o <= NOP_INSTR;
      pc_id_o <= pc;
      valid_o <= 1'b0;
    end else if (!stall_i) begin
      instr_o <= imem_data_i;
      pc_id_o <= pc;
      valid_o <= 1'b1;
    end
  end

`ifdef IF_ID_BUBBLE_CNT_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bubble_cnt_o <= '0;
    end else if (load_bubble && (bubble_cnt_o != '1)) begin
      bubble_cnt_o <= bubble_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: reference model plus directed literal checks.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rstN = 1'b1;
  logic [31:0] pcOut;
  logic [31:0] imemData;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        branchTaken = 1'b0;
  logic [31:0] branchTarget = 32'h0;
  logic [31:0] instrOut;
  logic [31:0] pcIdOut;
  logic        validOut;
`ifdef IF_ID_BUBBLE_CNT_EN
  logic [31:0] bubbleCnt;
`endif

  int  assertCount = 0;
  int  failCount = 0;
  bit  started = 1'b0;

  logic [31:0] mPc, mInstr, mPcId, mCnt;
  logic        mValid;

  if_id_stage dut (
    .clk_i          (clk),
    .rst_n_i        (rstN),
    .pc_o           (pcOut),
    .imem_data_i    (imemData),
    .stall_i        (stall),
    .flush_i        (flush),
    .branch_taken_i (branchTaken),
    .branch_target_i(branchTarget),
    .instr_o        (instrOut),
    .pc_id_o        (pcIdOut),
    .valid_o        (validOut)
`ifdef IF_ID_BUBBLE_CNT_EN
    ,
    .bubble_cnt_o   (bubbleCnt)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory contents: two fixed words, everything else address-derived.
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    if (addr == 32'h0) return 32'h00A0_0093;
    if (addr == 32'h4) return 32'h0010_0113;
    return addr ^ 32'hC0DE_0000;
  endfunction

  assign imemData = memWord(pcOut);

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: what a fetch stage must hold after each edge.
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mPc    <= 32'h0;
      mInstr <= 32'h13;
      mPcId  <= 32'h0;
      mValid <= 1'b0;
      mCnt   <= 32'h0;
    end else begin
      if (branchTaken)  mPc <= branchTarget;
      else if (!stall)  mPc <= mPc + 32'd4;
      if (flush || branchTaken) begin
        mInstr <= 32'h13;
        mPcId  <= mPc;
        mValid <= 1'b0;
        if (mCnt != 32'hFFFF_FFFF) mCnt <= mCnt + 32'd1;
      end else if (!stall) begin
        mInstr <= memWord(mPc);
        mPcId  <= mPc;
        mValid <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      checkOutput("model_pc", pcOut, mPc);
      checkOutput("model_instr", instrOut, mInstr);
      checkOutput("model_pc_id", pcIdOut, mPcId);
      checkOutput("model_valid", {31'b0, validOut}, {31'b0, mValid});
`ifdef IF_ID_BUBBLE_CNT_EN
      checkOutput("model_bubble_cnt", bubbleCnt, mCnt);
`endif
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic f, input logic b, input logic [31:0] t);
    stall = s;
    flush = f;
    branchTaken = b;
    branchTarget = t;
    stepCycle();
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_pc"}, pcOut, 32'h0);
    checkOutput({tag, "_instr"}, instrOut, 32'h13);
    checkOutput({tag, "_pc_id"}, pcIdOut, 32'h0);
    checkOutput({tag, "_valid"}, {31'b0, validOut}, 32'h0);
`ifdef IF_ID_BUBBLE_CNT_EN
    checkOutput({tag, "_cnt"}, bubbleCnt, 32'h0);
`endif
  endtask

  initial begin
    #2 rstN = 1'b0;
    started = 1'b1;
    #1 checkReset("reset");
    #9 rstN = 1'b1;
    #1 checkOutput("first_pc", pcOut, 32'h0);

    stepCycle();
    checkOutput("fetch0_pc", pcOut, 32'h4);
    checkOutput("fetch0_instr", instrOut, 32'h00A0_0093);
    checkOutput("fetch0_pc_id", pcIdOut, 32'h0);
    checkOutput("fetch0_valid", {31'b0, validOut}, 32'h1);
    stepCycle();
    checkOutput("fetch1_pc", pcOut, 32'h8);
    checkOutput("fetch1_instr", instrOut, 32'h0010_0113);
    checkOutput("fetch1_pc_id", pcIdOut, 32'h4);

    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("stall_pc", pcOut, 32'h8);
      checkOutput("stall_instr", instrOut, 32'h0010_0113);
      checkOutput("stall_pc_id", pcIdOut, 32'h4);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("resume_pc", pcOut, 32'hC);
    checkOutput("resume_pc_id", pcIdOut, 32'h8);

    applyStimulus(1'b1, 1'b0, 1'b1, 32'h40);
    checkOutput("branch_pc", pcOut, 32'h40);
    checkOutput("branch_instr", instrOut, 32'h13);
    checkOutput("branch_valid", {31'b0, validOut}, 32'h0);
    checkOutput("branch_pc_id", pcIdOut, 32'hC);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("target_pc", pcOut, 32'h44);
    checkOutput("target_instr", instrOut, 32'h40 ^ 32'hC0DE_0000);
    checkOutput("target_valid", {31'b0, validOut}, 32'h1);

    applyStimulus(1'b0, 1'b0, 1'b1, 32'h10);
    checkOutput("redirect10_pc", pcOut, 32'h10);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("flush_pc", pcOut, 32'h14);
    checkOutput("flush_instr", instrOut, 32'h13);
    checkOutput("flush_valid", {31'b0, validOut}, 32'h0);
    checkOutput("flush_pc_id", pcIdOut, 32'h10);

    applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    checkOutput("top_pc", pcOut, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("wrap_pc", pcOut, 32'h0);
    checkOutput("wrap_pc_id", pcIdOut, 32'hFFFF_FFFC);
    checkOutput("wrap_valid", {31'b0, validOut}, 32'h1);
`ifdef IF_ID_BUBBLE_CNT_EN
    checkOutput("pre_reset_cnt", bubbleCnt, 32'h4);
`endif

    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    #3 rstN = 1'b0;
    #1 checkReset("midstall_reset");
    stall = 1'b0;
    #1 rstN = 1'b1;
    stepCycle();
    checkOutput("post_reset_pc", pcOut, 32'h4);
    checkOutput("post_reset_instr", instrOut, 32'h00A0_0093);

    applyStimulus(1'b1, 1'b0, 1'b1, 32'h40);
`ifdef IF_ID_BUBBLE_CNT_EN
    checkOutput("cnt_after_branch", bubbleCnt, 32'h1);
`endif
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("flush2_pc", pcOut, 32'h44);
`ifdef IF_ID_BUBBLE_CNT_EN
    checkOutput("cnt_after_flush", bubbleCnt, 32'h2);
`endif
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("held_bubble_valid", {31'b0, validOut}, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    stepCycle();
    stepCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
